// File: rtl/dl_write_ctl_if.sv
// Load-request handshake between the host and the delay-line write sequencer.
// The master raises ld_req and the slave answers with ld_ack and busy.
interface dl_write_ctl_if #(
  parameter int BITS = 28
) ();
  logic            ld_req;
  logic [1:0]      ld_chan;
  logic [BITS-1:0] ld_data;
  logic            ld_ack;
  logic            busy;

  modport master (
    output ld_req,
    output ld_chan,
    output ld_data,
    input  ld_ack,
    input  busy
  );

  modport slave (
    input  ld_req,
    input  ld_chan,
    input  ld_data,
    output ld_ack,
    output busy
  );
endinterface

// File: rtl/dl_write_ctl.sv
// Write-side sequencer for a 4-channel serial delay line: recirculates sense-amp bits or inserts a loaded word.
// Optional feature macro DL_PARITY_EN: generated odd-parity MSB plus a sticky recirculation parity checker.
module dl_write_ctl #(
  parameter int BITS = 28,
  parameter int BW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sa_in,
  dl_write_ctl_if.slave     ld,
  output logic              dl_out,
  output logic [1:0]        phase,
  output logic [BW-1:0]     bit_idx,
  output logic              word_sync,
  output logic              perr
);

  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_INSERT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BITS-1:0] shadow_q, shadow_d;
  logic [1:0]      chan_q, chan_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            dl_q, dl_d;
  logic            word_sync_s;
  logic            accept_s;
  logic            insert_slot_s;
  logic [BITS-1:0] new_word_s;

  assign word_sync_s   = (phase_q == 2'd3) && (bit_q == LAST_BIT);
  assign insert_slot_s = (state_q == S_INSERT) && (phase_q == chan_q);

`ifdef DL_PARITY_EN
  assign new_word_s = {~^ld.ld_data[BITS-2:0], ld.ld_data[BITS-2:0]};
`else
  assign new_word_s = ld.ld_data;
`endif

  always_comb begin
    phase_d = phase_q + 2'd1;
    bit_d   = bit_q;
    if (phase_q == 2'd3) begin
      bit_d = (bit_q == LAST_BIT) ? {BW{1'b0}} : bit_q + BW'(1);
    end else begin
      bit_d = bit_q;
    end
  end

  // Requests are only ever accepted on the last slot of a word, so insertion spans one whole word.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld.ld_req && word_sync_s) begin
          accept_s = 1'b1;
          state_d  = S_INSERT;
        end else if (ld.ld_req) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (!ld.ld_req) begin
          state_d = S_IDLE;
        end else if (word_sync_s) begin
          accept_s = 1'b1;
          state_d  = S_INSERT;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_INSERT: begin
        if (word_sync_s && ld.ld_req) begin
          accept_s = 1'b1;
          state_d  = S_INSERT;
        end else if (word_sync_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INSERT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    shadow_d = accept_s ? new_word_s : shadow_q;
    chan_d   = accept_s ? ld.ld_chan : chan_q;
    ack_d    = accept_s;
    if (accept_s) begin
      busy_d = 1'b1;
    end else if ((state_q == S_INSERT) && word_sync_s) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    dl_d = insert_slot_s ? shadow_q[bit_q] : sa_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= 2'd0;
      bit_q    <= {BW{1'b0}};
      shadow_q <= {BITS{1'b0}};
      chan_q   <= 2'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      chan_q   <= chan_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      dl_q     <= dl_d;
    end
  end

`ifdef DL_PARITY_EN
  logic [3:0] par_q, par_d;
  logic       perr_q, perr_d;

  // Channel 3's final bit is still on sa_in at word_sync, so it is folded in here.
  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    for (int c = 0; c < 4; c++) begin
      if (word_sync_s) begin
        if (!(par_q[c] ^ ((c == 3) ? sa_in : 1'b0)) &&
            !((state_q == S_INSERT) && (chan_q == 2'(c)))) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_d;
        end
        par_d[c] = 1'b0;
      end else if (phase_q == 2'(c)) begin
        par_d[c] = par_q[c] ^ sa_in;
      end else begin
        par_d[c] = par_q[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 4'd0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign ld.ld_ack = ack_q;
  assign ld.busy   = busy_q;
  assign dl_out    = dl_q;
  assign phase     = phase_q;
  assign bit_idx   = bit_q;
  assign word_sync = word_sync_s;

endmodule
